kplic: RTL and testbench



---
 rtl/kplic_if.sv | 18 +
 rtl/kplic.sv | 177 +++++++++++++++++
 tb/tb_kplic.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kplic_if.sv
// Register bus between the core and the kplic interrupt controller.
interface kplic_if;
    logic [7:0]  kplic_addr;
    logic        kplic_rd;
    logic        kplic_wr;
    logic [31:0] kplic_wdata;
    logic [31:0] kplic_rdata;

    modport master (
        output kplic_addr, kplic_rd, kplic_wr, kplic_wdata,
        input  kplic_rdata
    );

    modport slave (
        input  kplic_addr, kplic_rd, kplic_wr, kplic_wdata,
        output kplic_rdata
    );
endinterface

// File: rtl/kplic.sv
// Platform-level external interrupt controller: gateways, priority arbiter, claim/complete.
// Optional edge-triggered sources are built when KPLIC_EDGE_TRIG_EN is defined.
module kplic #(
    parameter int SRC_NUM    = 8,
    parameter int PRIO_WIDTH = 3
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [SRC_NUM-1:0] irq_src,
    kplic_if.slave             bus,
    output logic               kplic_int
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PENDING    = 2'd1;
    localparam logic [1:0] ST_IN_SERVICE = 2'd2;

    localparam logic [7:0] ADDR_PENDING   = 8'h40;
    localparam logic [7:0] ADDR_ENABLE    = 8'h41;
    localparam logic [7:0] ADDR_THRESHOLD = 8'h42;
    localparam logic [7:0] ADDR_CLAIM     = 8'h43;
    localparam logic [7:0] ADDR_TRIG      = 8'h44;

    logic [SRC_NUM:1]      s_meta;
    logic [SRC_NUM:1]      s_src;
    logic [SRC_NUM:1]      trig;
    logic [SRC_NUM:1]      enable;
    logic [SRC_NUM:1]      pend_vec;
    logic [PRIO_WIDTH-1:0] prio [1:SRC_NUM];
    logic [PRIO_WIDTH-1:0] threshold;
    logic [1:0]            gw [1:SRC_NUM];

    logic [4:0]            win_id;
    logic [PRIO_WIDTH-1:0] win_prio;
    logic [4:0]            claim_id;
    logic                  claim_fire;
    logic                  cmpl_fire;
    logic [4:0]            cmpl_id;
    logic [31:0]           rd_mux;
    logic                  unused_bus;

`ifdef KPLIC_EDGE_TRIG_EN
    logic [SRC_NUM:1]      edge_mode;
    logic [SRC_NUM:1]      s_prev;
    logic [SRC_NUM:1]      rise;
    logic [SRC_NUM:1]      deferred;
`endif

    assign unused_bus = ^bus.kplic_wdata;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            s_meta <= '0;
            s_src  <= '0;
        end else begin
            s_meta <= irq_src;
            s_src  <= s_meta;
        end
    end

`ifdef KPLIC_EDGE_TRIG_EN
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) s_prev <= '0;
        else         s_prev <= s_src;
    end

    assign rise = s_src & ~s_prev;
    assign trig = (edge_mode & rise) | (~edge_mode & s_src);
`else
    assign trig = s_src;
`endif

    // Strict '>' keeps the lowest ID on ties; a zero priority never beats the initial 0.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        pend_vec = '0;
        for (int i = 1; i <= SRC_NUM; i++) begin
            pend_vec[i] = (gw[i] == ST_PENDING);
            if (gw[i] == ST_PENDING && enable[i] && prio[i] > win_prio) begin
                win_id   = 5'(i);
                win_prio = prio[i];
            end
        end
    end

    assign claim_id   = (win_prio > threshold) ? win_id : 5'd0;
    assign claim_fire = bus.kplic_rd && !bus.kplic_wr && bus.kplic_addr == ADDR_CLAIM;
    assign cmpl_fire  = bus.kplic_wr && bus.kplic_addr == ADDR_CLAIM;
    assign cmpl_id    = bus.kplic_wdata[4:0];

    always_comb begin
        rd_mux = '0;
        for (int i = 1; i <= SRC_NUM; i++) begin
            if (bus.kplic_addr == 8'(i)) rd_mux = 32'(prio[i]);
        end
        case (bus.kplic_addr)
            ADDR_PENDING:   rd_mux = 32'({pend_vec, 1'b0});
            ADDR_ENABLE:    rd_mux = 32'({enable, 1'b0});
            ADDR_THRESHOLD: rd_mux = 32'(threshold);
            ADDR_CLAIM:     rd_mux = 32'(claim_id);
`ifdef KPLIC_EDGE_TRIG_EN
            ADDR_TRIG:      rd_mux = 32'({edge_mode, 1'b0});
`endif
            default:        ;
        endcase
    end

    // A write wins over a simultaneous read, so the read data simply holds.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            bus.kplic_rdata <= '0;
            kplic_int       <= 1'b0;
        end else begin
            if (bus.kplic_rd && !bus.kplic_wr) bus.kplic_rdata <= rd_mux;
            kplic_int <= (win_prio > threshold);
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            for (int i = 1; i <= SRC_NUM; i++) prio[i] <= '0;
            enable    <= '0;
            threshold <= '0;
`ifdef KPLIC_EDGE_TRIG_EN
            edge_mode <= '0;
`endif
        end else if (bus.kplic_wr) begin
            for (int i = 1; i <= SRC_NUM; i++) begin
                if (bus.kplic_addr == 8'(i)) prio[i] <= bus.kplic_wdata[PRIO_WIDTH-1:0];
            end
            case (bus.kplic_addr)
                ADDR_ENABLE:    enable    <= bus.kplic_wdata[SRC_NUM:1];
                ADDR_THRESHOLD: threshold <= bus.kplic_wdata[PRIO_WIDTH-1:0];
`ifdef KPLIC_EDGE_TRIG_EN
                ADDR_TRIG:      edge_mode <= bus.kplic_wdata[SRC_NUM:1];
`endif
                default:        ;
            endcase
        end
    end

    // Completing an ID that is not in service (or out of range) matches no gateway.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            for (int i = 1; i <= SRC_NUM; i++) gw[i] <= ST_IDLE;
`ifdef KPLIC_EDGE_TRIG_EN
            deferred <= '0;
`endif
        end else begin
            for (int i = 1; i <= SRC_NUM; i++) begin
                case (gw[i])
                    ST_IDLE: begin
                        if (trig[i]) gw[i] <= ST_PENDING;
                    end
                    ST_PENDING: begin
                        if (claim_fire && claim_id == 5'(i)) gw[i] <= ST_IN_SERVICE;
                    end
                    ST_IN_SERVICE: begin
`ifdef KPLIC_EDGE_TRIG_EN
                        if (cmpl_fire && cmpl_id == 5'(i)) begin
                            gw[i]       <= (deferred[i] || (edge_mode[i] && rise[i])) ? ST_PENDING : ST_IDLE;
                            deferred[i] <= 1'b0;
                        end else if (edge_mode[i] && rise[i]) begin
                            deferred[i] <= 1'b1;
                        end
`else
                        if (cmpl_fire && cmpl_id == 5'(i)) gw[i] <= ST_IDLE;
`endif
                    end
                    default: gw[i] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kplic.sv
// Self-checking bench for kplic: register table vectors plus handshake sequences.
// Edge-trigger sequences run only when KPLIC_EDGE_TRIG_EN is defined.
module tb_kplic;
    localparam int SRC_NUM    = 8;
    localparam int PRIO_WIDTH = 3;

    logic               cpu_clk = 1'b0;
    logic               cpu_rst;
    logic [SRC_NUM-1:0] irq_src;
    logic               kplic_int;
    logic [31:0]        rv;

    int n_checks = 0;
    int n_fail   = 0;

    kplic_if bus ();

    kplic #(.SRC_NUM(SRC_NUM), .PRIO_WIDTH(PRIO_WIDTH)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .irq_src   (irq_src),
        .bus       (bus),
        .kplic_int (kplic_int)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus.kplic_addr  = a;
        bus.kplic_wdata = d;
        bus.kplic_wr    = 1'b1;
        tick();
        bus.kplic_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bus.kplic_addr = a;
        bus.kplic_rd   = 1'b1;
        tick();
        bus.kplic_rd   = 1'b0;
        d = bus.kplic_rdata;
    endtask

    task automatic check_read(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        checkOutput(name, d, exp);
    endtask

    task automatic do_reset();
        irq_src         = '0;
        bus.kplic_rd    = 1'b0;
        bus.kplic_wr    = 1'b0;
        bus.kplic_addr  = '0;
        bus.kplic_wdata = '0;
        cpu_rst         = 1'b1;
        tick();
        cpu_rst         = 1'b0;
        tick();
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] d;
        if (v.wr) begin
            bus_write(v.addr, v.wdata);
        end else begin
            bus_read(v.addr, d);
            checkOutput($sformatf("vec%0d_rd_0x%0h", idx, v.addr), d, v.exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h01, 32'h5,    32'h0};
        vecs[1]  = '{1'b0, 8'h01, 32'h0,    32'h5};
        vecs[2]  = '{1'b1, 8'h08, 32'hFF,   32'h0};
        vecs[3]  = '{1'b0, 8'h08, 32'h0,    32'h7};
        vecs[4]  = '{1'b0, 8'h09, 32'h0,    32'h0};
        vecs[5]  = '{1'b1, 8'h41, 32'hFFFF, 32'h0};
        vecs[6]  = '{1'b0, 8'h41, 32'h0,    32'h1FE};
        vecs[7]  = '{1'b1, 8'h42, 32'h0A,   32'h0};
        vecs[8]  = '{1'b0, 8'h42, 32'h0,    32'h2};
        vecs[9]  = '{1'b1, 8'h40, 32'hFF,   32'h0};
        vecs[10] = '{1'b0, 8'h40, 32'h0,    32'h0};
        vecs[11] = '{1'b0, 8'h43, 32'h0,    32'h0};
        vecs[12] = '{1'b1, 8'h44, 32'h06,   32'h0};
`ifdef KPLIC_EDGE_TRIG_EN
        vecs[13] = '{1'b0, 8'h44, 32'h0,    32'h06};
`else
        vecs[13] = '{1'b0, 8'h44, 32'h0,    32'h0};
`endif
        vecs[14] = '{1'b1, 8'h30, 32'hFF,   32'h0};
        vecs[15] = '{1'b0, 8'h30, 32'h0,    32'h0};

        // Reset values observed while reset is still asserted
        irq_src         = '0;
        bus.kplic_rd    = 1'b0;
        bus.kplic_wr    = 1'b0;
        bus.kplic_addr  = '0;
        bus.kplic_wdata = '0;
        cpu_rst         = 1'b1;
        #3;
        checkOutput("reset_int", 32'(kplic_int), 32'h0);
        checkOutput("reset_rdata", bus.kplic_rdata, 32'h0);
        do_reset();

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

        // Basic latency: four edges from irq_src to kplic_int
        do_reset();
        bus_write(8'h03, 32'd2);
        bus_write(8'h41, 32'h08);
        bus_write(8'h42, 32'd0);
        irq_src[2] = 1'b1;
        repeat (3) tick();
        checkOutput("lat_int_edge3", 32'(kplic_int), 32'h0);
        tick();
        checkOutput("lat_int_edge4", 32'(kplic_int), 32'h1);
        check_read("lat_pending", 8'h40, 32'h08);

        // Arbitration, ignored complete, int drop, complete re-pend
        do_reset();
        bus_write(8'h01, 32'd5);
        bus_write(8'h02, 32'd5);
        bus_write(8'h04, 32'd6);
        bus_write(8'h41, 32'h16);
        irq_src = 8'b0000_1011;
        repeat (5) tick();
        checkOutput("arb_int", 32'(kplic_int), 32'h1);
        check_read("arb_pending", 8'h40, 32'h16);
        check_read("arb_claim_4", 8'h43, 32'd4);
        bus_write(8'h43, 32'd2);
        check_read("arb_cmpl2_ignored", 8'h40, 32'h06);
        check_read("arb_claim_1", 8'h43, 32'd1);
        check_read("arb_claim_2", 8'h43, 32'd2);
        tick();
        checkOutput("arb_int_dropped", 32'(kplic_int), 32'h0);
        bus_write(8'h43, 32'd7);
        check_read("arb_cmpl7_ignored", 8'h40, 32'h0);
        bus_write(8'h43, 32'd4);
        check_read("arb_cmpl4_idle", 8'h40, 32'h0);
        checkOutput("arb_cmpl4_int_low", 32'(kplic_int), 32'h0);
        check_read("arb_cmpl4_repend", 8'h40, 32'h10);
        checkOutput("arb_cmpl4_int_high", 32'(kplic_int), 32'h1);

        // Threshold masking and simultaneous read/write on the claim register
        do_reset();
        bus_write(8'h05, 32'd3);
        bus_write(8'h41, 32'h20);
        bus_write(8'h42, 32'd3);
        irq_src[4] = 1'b1;
        repeat (5) tick();
        checkOutput("thr_int_masked", 32'(kplic_int), 32'h0);
        check_read("thr_claim_0", 8'h43, 32'd0);
        check_read("thr_pending", 8'h40, 32'h20);
        bus_write(8'h42, 32'd2);
        checkOutput("thr_int_edge1", 32'(kplic_int), 32'h0);
        tick();
        checkOutput("thr_int_edge2", 32'(kplic_int), 32'h1);
        bus.kplic_addr  = 8'h43;
        bus.kplic_wdata = 32'h0;
        bus.kplic_rd    = 1'b1;
        bus.kplic_wr    = 1'b1;
        tick();
        bus.kplic_rd    = 1'b0;
        bus.kplic_wr    = 1'b0;
        checkOutput("rdwr_rdata_hold", bus.kplic_rdata, 32'h20);
        check_read("rdwr_no_claim", 8'h40, 32'h20);
        check_read("thr_claim_5", 8'h43, 32'd5);

        // Asynchronous reset while source 1 is in service
        do_reset();
        bus_write(8'h01, 32'd1);
        bus_write(8'h02, 32'd1);
        bus_write(8'h41, 32'h06);
        irq_src = 8'b0000_0011;
        repeat (5) tick();
        check_read("rst_claim_1", 8'h43, 32'd1);
        tick();
        checkOutput("rst_int_before", 32'(kplic_int), 32'h1);
        #2;
        cpu_rst = 1'b1;
        #1;
        checkOutput("rst_int_async", 32'(kplic_int), 32'h0);
        checkOutput("rst_rdata_async", bus.kplic_rdata, 32'h0);
        irq_src = '0;
        tick();
        cpu_rst = 1'b0;
        check_read("rst_pending", 8'h40, 32'h0);
        check_read("rst_enable", 8'h41, 32'h0);
        check_read("rst_prio1", 8'h01, 32'h0);

`ifdef KPLIC_EDGE_TRIG_EN
        // Edge mode: pulse, deferred re-pend on complete
        do_reset();
        bus_write(8'h44, 32'h02);
        bus_write(8'h01, 32'd1);
        bus_write(8'h41, 32'h02);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        repeat (4) tick();
        check_read("edge_pending", 8'h40, 32'h02);
        check_read("edge_claim_1", 8'h43, 32'd1);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        repeat (4) tick();
        check_read("edge_in_service", 8'h40, 32'h0);
        bus_write(8'h43, 32'd1);
        check_read("edge_deferred_pend", 8'h40, 32'h02);
        check_read("edge_claim_again", 8'h43, 32'd1);
        bus_write(8'h43, 32'd1);
        repeat (2) tick();
        check_read("edge_claim_none", 8'h43, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
